// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table capture block.
// Default input count, table width helper and FSM state encoding.
package tt_pkg;

    localparam int TT_NUM_INPUTS = 7;

    function automatic int tt_width(input int n);
        return 2 ** n;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tt_state_e;

endpackage

// File: rtl/tt_lat_pipe.sv
// Delay line carrying {valid, index} alongside the FUT latency.
// Reset clears only the valid bits; indices are don't-care when invalid.
module tt_lat_pipe #(
    parameter int PIPE_LAT = 1,
    parameter int IW       = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [IW-1:0] idx_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    generate
        if (PIPE_LAT == 0) begin : g_pass
            assign valid_o = valid_i;
            assign idx_o   = idx_i;
        end else begin : g_shift
            logic [PIPE_LAT-1:0] vld_q;
            logic [IW-1:0]       idx_q [PIPE_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= valid_i;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                idx_q[0] <= idx_i;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    idx_q[i] <= idx_q[i-1];
                end
            end

            assign valid_o = vld_q[PIPE_LAT-1];
            assign idx_o   = idx_q[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all FUT input patterns and packs the sampled output into tt.
// Define TT_POPCOUNT_EN to add the running ones_cnt output.
module truth_table_capture
    import tt_pkg::*;
#(
    parameter int NUM_INPUTS = TT_NUM_INPUTS,
    parameter int PIPE_LAT   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_INPUTS-1:0]           pattern,
    input  logic                            fut_out,
    output logic [tt_width(NUM_INPUTS)-1:0] tt,
    output logic                            tt_valid
`ifdef TT_POPCOUNT_EN
    ,
    output logic [NUM_INPUTS:0]             ones_cnt
`endif
);

    localparam int TTW = tt_width(NUM_INPUTS);
    localparam int CW  = NUM_INPUTS + 1;
    localparam logic [CW-1:0] SWEEP_LAST = CW'(TTW - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    tt_state_e           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TTW-1:0]      tt_q, tt_d;
    logic                tt_valid_q, tt_valid_d;
    logic                accept;
    logic                sw_vld, smp_vld;
    logic [NUM_INPUTS-1:0] sw_idx, smp_idx;

    assign sw_vld = (state_q == SWEEP);
    assign sw_idx = cnt_q[NUM_INPUTS-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end
            end
            SWEEP: begin
                if (cnt_q == SWEEP_LAST) begin
                    cnt_d   = '0;
                    state_d = (PIPE_LAT > 0) ? DRAIN : DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Samples arrive PIPE_LAT cycles after their pattern was driven
    generate
        if (PIPE_LAT > 0) begin : g_pipe
            tt_lat_pipe #(
                .PIPE_LAT (PIPE_LAT),
                .IW       (NUM_INPUTS)
            ) u_pipe (
                .clk     (clk),
                .rst     (rst),
                .valid_i (sw_vld),
                .idx_i   (sw_idx),
                .valid_o (smp_vld),
                .idx_o   (smp_idx)
            );
        end else begin : g_comb
            assign smp_vld = sw_vld;
            assign smp_idx = sw_idx;
        end
    endgenerate

    always_comb begin
        tt_d       = tt_q;
        tt_valid_d = tt_valid_q;
        if (accept) begin
            tt_d       = '0;
            tt_valid_d = 1'b0;
        end else begin
            if (smp_vld) begin
                tt_d[smp_idx] = fut_out;
            end
            if (state_d == DONE) begin
                tt_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tt_q       <= tt_d;
            tt_valid_q <= tt_valid_d;
        end
    end

`ifdef TT_POPCOUNT_EN
    logic [NUM_INPUTS:0] ones_q, ones_d;

    always_comb begin
        ones_d = ones_q;
        if (accept) begin
            ones_d = '0;
        end else if (smp_vld && fut_out) begin
            ones_d = ones_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones_cnt = ones_q;
`endif

    assign pattern  = sw_vld ? sw_idx : '0;
    assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign tt       = tt_q;
    assign tt_valid = tt_valid_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: one combinational-FUT instance and one
// instance with a twice-registered FUT, checked against a reference table.
module tb_truth_table_capture;
    import tt_pkg::*;

    localparam int N = 7;
    localparam int W = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start0 = 1'b0;
    logic         start2 = 1'b0;
    logic         fut0, fut2;
    logic         busy0, done0, tv0;
    logic         busy2, done2, tv2;
    logic [N-1:0] pat0, pat2;
    logic [W-1:0] tt0, tt2;
`ifdef TT_POPCOUNT_EN
    logic [N:0]   oc0, oc2;
`endif
    int           fsel = 0;
    logic         r1 = 1'b0;
    logic         r2 = 1'b0;
    int           checks = 0;
    int           errors = 0;

    function automatic logic fmodel(input int sel, input logic [N-1:0] p);
        case (sel)
            0:       return p[0];
            1:       return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
            2:       return 1'b1;
            default: return ($countones(p) >= 4);
        endcase
    endfunction

    assign fut0 = fmodel(fsel, pat0);

    always @(posedge clk) begin
        r1 <= fmodel(3, pat2);
        r2 <= r1;
    end
    assign fut2 = r2;

    truth_table_capture #(.NUM_INPUTS(N), .PIPE_LAT(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start0),
        .busy     (busy0),
        .done     (done0),
        .pattern  (pat0),
        .fut_out  (fut0),
        .tt       (tt0),
        .tt_valid (tv0)
`ifdef TT_POPCOUNT_EN
        ,
        .ones_cnt (oc0)
`endif
    );

    truth_table_capture #(.NUM_INPUTS(N), .PIPE_LAT(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .busy     (busy2),
        .done     (done2),
        .pattern  (pat2),
        .fut_out  (fut2),
        .tt       (tt2),
        .tt_valid (tv2)
`ifdef TT_POPCOUNT_EN
        ,
        .ones_cnt (oc2)
`endif
    );

    typedef struct {
        logic [W-1:0] tt;
        int           lat;
        int           ones;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] get_tt(input int d);
        return (d == 0) ? tt0 : tt2;
    endfunction
    function automatic logic [N-1:0] get_pat(input int d);
        return (d == 0) ? pat0 : pat2;
    endfunction
    function automatic logic get_done(input int d);
        return (d == 0) ? done0 : done2;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy2;
    endfunction
    function automatic logic get_tv(input int d);
        return (d == 0) ? tv0 : tv2;
    endfunction
`ifdef TT_POPCOUNT_EN
    function automatic logic [N:0] get_ones(input int d);
        return (d == 0) ? oc0 : oc2;
    endfunction
`endif

    task automatic set_start(input int d, input logic v);
        if (d == 0) start0 = v;
        else        start2 = v;
    endtask

    task automatic push_exp(input int sel, input int lat);
        exp_t e;
        e.tt   = '0;
        e.ones = 0;
        e.lat  = lat;
        for (int k = 0; k < W; k++) begin
            e.tt[k] = fmodel(sel, N'(k));
            if (e.tt[k]) e.ones++;
        end
        sb.push_back(e);
    endtask

    // Entered at the negedge of cycle 1; returns at the negedge of done
    task automatic wait_done(input int d, input int restart_at);
        exp_t e;
        int   n;
        bit   seen;
        e    = sb.pop_front();
        n    = 1;
        seen = 1'b0;
        check("busy_c1", W'(get_busy(d)), W'(1));
        check("tv_c1", W'(get_tv(d)), W'(0));
        while (n <= 400 && !seen) begin
            if (n == restart_at) set_start(d, 1'b1);
            else if (n == restart_at + 1) set_start(d, 1'b0);
            if (n <= W + e.lat + 1)
                check("pattern", W'(get_pat(d)), W'((n <= W) ? n - 1 : 0));
            if (get_done(d)) begin
                seen = 1'b1;
                check("done_cyc", W'(n), W'(W + e.lat + 1));
                check("tt", get_tt(d), e.tt);
                check("tt_valid", W'(get_tv(d)), W'(1));
                check("busy_done", W'(get_busy(d)), W'(0));
`ifdef TT_POPCOUNT_EN
                check("ones_cnt", W'(get_ones(d)), W'(e.ones));
`endif
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) check("done_timeout", W'(0), W'(1));
    endtask

    task automatic capture(input int d, input int sel, input int restart_at,
                           input bit chain);
        if (d == 0) fsel = sel;
        push_exp(sel, d);
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        wait_done(d, restart_at);
        if (chain) begin
            push_exp(sel, d);
            set_start(d, 1'b1);
            @(negedge clk);
            set_start(d, 1'b0);
            check("chain_tt", get_tt(d), '0);
            check("chain_tv", W'(get_tv(d)), W'(0));
            wait_done(d, -10);
        end
        @(negedge clk);
    endtask

    task automatic rst_test();
        int dn;
        dn   = 0;
        fsel = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_state", W'(u_dut0.state_q), W'(IDLE));
        check("rst_busy", W'(busy0), W'(0));
        check("rst_tt", tt0, '0);
        check("rst_tv", W'(tv0), W'(0));
        check("rst_pat", W'(pat0), W'(0));
        check("rst_done", W'(done0), W'(0));
        repeat (200) begin
            @(negedge clk);
            if (done0) dn++;
        end
        check("rst_nodone", W'(dn), W'(0));
    endtask

    logic [W-1:0] c_aa, c_e8, c_ones;

    initial begin
        c_aa   = {16{8'hAA}};
        c_e8   = {16{8'hE8}};
        c_ones = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tt", tt0, '0);
        check("reset_tv", W'(tv0), W'(0));
        check("reset_busy", W'(busy0), W'(0));
        check("reset_done", W'(done0), W'(0));
        check("reset_pat", W'(pat0), W'(0));
        check("reset_busy2", W'(busy2), W'(0));

        capture(0, 0, -10, 1'b0);
        check("x0_const", tt0, c_aa);
        capture(0, 1, -10, 1'b0);
        check("maj3_const", tt0, c_e8);
        capture(2, 3, -10, 1'b0);
        capture(0, 2, -10, 1'b1);
        check("ones_const", tt0, c_ones);
        capture(0, 0, 50, 1'b0);
        check("restart_const", tt0, c_aa);
        rst_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
